// File: rtl/din_debounce_if.sv
// Signal bundle between a raw input source and the debounce stage.
// The source drives din; the debouncer returns the conditioned level and strobes.
interface din_debounce_if;
  logic din;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output din,
    input  q,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  din,
    output q,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/din_debounce.sv
// Two-flop synchroniser plus stability qualifier for a raw asynchronous input.
// All state moves on posedge ck, so q is settled well before a downstream falling-edge sample.
module din_debounce #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 4
) (
  input logic          ck,
  input logic          rst_n,
  din_debounce_if.slave bus
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             s2;
  logic             q_r;
  logic             rise_r;
  logic             fall_r;

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      state  <= STABLE;
    end else begin
      s1     <= bus.din;
      s2     <= s1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != q_r) begin
            state <= CHECK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        CHECK: begin
          if (s2 == q_r) begin
            // candidate reverted before qualifying: drop it silently
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            q_r    <= s2;
            rise_r <= s2;
            fall_r <= ~s2;
            state  <= STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;
  assign bus.busy = (state == CHECK);

  strobe_exclusive: assert property (@(posedge ck) !(rise_r && fall_r));

endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce with hand-derived edge-by-edge expectations.
module tb_din_debounce;

  logic ck;
  logic rst_n;
  logic dff;
  int   checks;
  int   errors;

  din_debounce_if bus ();

  din_debounce #(
    .STABLE_CNT(4),
    .CNT_W     (4)
  ) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    ck = 1'b0;
    forever #50 ck = ~ck;
  end

  // stand-in for the downstream negedge-sampled register
  always @(negedge ck) dff <= bus.q;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      #1;
    end
  endtask

  // steps n edges; vector bit i is the expected value just after edge i
  task automatic run_seq(input string tag, input int n,
                         input logic [0:15] eq, input logic [0:15] er,
                         input logic [0:15] ef, input logic [0:15] eb);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      #1;
      check($sformatf("%s.q%0d", tag, i),    bus.q,    eq[i]);
      check($sformatf("%s.rise%0d", tag, i), bus.rise, er[i]);
      check($sformatf("%s.fall%0d", tag, i), bus.fall, ef[i]);
      check($sformatf("%s.busy%0d", tag, i), bus.busy, eb[i]);
    end
  endtask

  task automatic chained(input string tag, input int len, input logic [0:15] exp_dff);
    bus.din = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge ck);
      @(negedge ck);
      #1;
      check($sformatf("%s.dff%0d", tag, i), dff, exp_dff[i]);
      bus.din = (i + 1 < len);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.din = 1'b1;

    tick(2);
    check("rst.q",    bus.q,    1'b0);
    check("rst.rise", bus.rise, 1'b0);
    check("rst.fall", bus.fall, 1'b0);
    check("rst.busy", bus.busy, 1'b0);

    rst_n = 1'b1;
    run_seq("release", 7, 16'b0000011000000000, 16'b0000010000000000,
            16'b0000000000000000, 16'b0011100000000000);

    bus.din = 1'b0;
    run_seq("fallstep", 7, 16'b1111100000000000, 16'b0000000000000000,
            16'b0000010000000000, 16'b0011100000000000);

    bus.din = 1'b1;
    run_seq("risestep", 10, 16'b0000011111000000, 16'b0000010000000000,
            16'b0000000000000000, 16'b0011100000000000);

    bus.din = 1'b0;
    tick(8);
    check("settle0.q", bus.q, 1'b0);

    bus.din = 1'b1;
    run_seq("glitch.a", 2, 16'b0, 16'b0, 16'b0, 16'b0);
    bus.din = 1'b0;
    run_seq("glitch.b", 6, 16'b0, 16'b0, 16'b0, 16'b1100000000000000);

    bus.din = 1'b1;
    run_seq("pulse3.a", 3, 16'b0, 16'b0, 16'b0, 16'b0010000000000000);
    bus.din = 1'b0;
    run_seq("pulse3.b", 6, 16'b0, 16'b0, 16'b0, 16'b1100000000000000);

    bus.din = 1'b1;
    run_seq("pulse4.a", 4, 16'b0, 16'b0, 16'b0, 16'b0011000000000000);
    bus.din = 1'b0;
    run_seq("pulse4.b", 7, 16'b0111100000000000, 16'b0100000000000000,
            16'b0000010000000000, 16'b1011100000000000);

    bus.din = 1'b1;
    run_seq("midrst.a", 3, 16'b0, 16'b0, 16'b0, 16'b0010000000000000);
    rst_n = 1'b0;
    run_seq("midrst.b", 1, 16'b0, 16'b0, 16'b0, 16'b0);
    rst_n = 1'b1;
    run_seq("midrst.c", 7, 16'b0000011000000000, 16'b0000010000000000,
            16'b0000000000000000, 16'b0011100000000000);

    bus.din = 1'b0;
    tick(8);
    check("settle1.q", bus.q, 1'b0);

    chained("chain3", 3, 16'b0000000000000000);
    chained("chain6", 6, 16'b0000011111100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
